// File: rtl/siteswap_loader.sv
// siteswap_loader
//   Collects siteswap throw digits from the user-input path and validates the
//   pattern when the user commits it. A pattern is accepted only if its
//   average throw is an integer, no two throws land on the same beat, and the
//   ball count is non-zero. The accepted pattern is published, periodically
//   extended to MAX_LEN entries, in the form trajectory_generator consumes.
//
//   Optional build macro: SITESWAP_MAXHEIGHT_EN
//     Rejects any throw above MAX_THROW (error code 5) and adds max_throw_out.
//
// Ports
//   clk_in, rst_in        clock, asynchronous active-high reset
//   digit_in/_valid_in    throw digit and its one-cycle append strobe
//   commit_in             one-cycle strobe, starts validation
//   clear_in              one-cycle strobe, discards entry and result
//   pattern_out[k]        p[k mod len] of the validated pattern
//   num_balls_out         sum / len of the validated pattern
//   len_out               digits currently held in the entry buffer
//   pattern_valid_out     level, result valid
//   busy_out              validation in progress (SUM/DIV/CHK)
//   error_out             level, validation failed
//   error_code_out        0 none, 1 empty, 2 non-integer avg, 3 collision,
//                         4 zero balls, 5 throw too high
//   max_throw_out         largest throw of the valid pattern (macro only)
module siteswap_loader #(
    parameter int MAX_LEN   = 7,
    parameter int MAX_THROW = 7
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [2:0] digit_in,
    input  logic       digit_valid_in,
    input  logic       commit_in,
    input  logic       clear_in,
    output logic [2:0] pattern_out [MAX_LEN-1:0],
    output logic [2:0] num_balls_out,
    output logic [2:0] len_out,
    output logic       pattern_valid_out,
    output logic       busy_out,
    output logic       error_out,
    output logic [2:0] error_code_out
`ifdef SITESWAP_MAXHEIGHT_EN
    ,
    output logic [2:0] max_throw_out
`endif
);

    // All digit, index and count fields are 3 bits wide.
    if (MAX_LEN < 1 || MAX_LEN > 7 || MAX_THROW < 0 || MAX_THROW > 7) begin : g_bad_params
        $error("siteswap_loader: MAX_LEN must be 1..7 and MAX_THROW 0..7");
    end

    typedef enum logic [2:0] {
        S_ENTRY,
        S_SUM,
        S_DIV,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [2:0] LEN_FULL  = 3'(MAX_LEN);
    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_EMPTY = 3'd1;
    localparam logic [2:0] ERR_FRAC  = 3'd2;
    localparam logic [2:0] ERR_COLL  = 3'd3;
    localparam logic [2:0] ERR_ZERO  = 3'd4;
`ifdef SITESWAP_MAXHEIGHT_EN
    localparam logic [2:0] ERR_HIGH  = 3'd5;
    localparam logic [3:0] THROW_LIM = 4'(MAX_THROW);
`endif

    state_t             state_q, state_d;
    logic [2:0]         pbuf_q [MAX_LEN-1:0];
    logic [2:0]         pbuf_d [MAX_LEN-1:0];
    logic [2:0]         len_q, len_d;
    logic [2:0]         idx_q, idx_d;
    logic [5:0]         acc_q, acc_d;       // sum, then remainder during DIV
    logic [2:0]         q_q, q_d;           // quotient = ball count
    logic [MAX_LEN-1:0] occ_q, occ_d;       // landing-beat occupancy
    logic [2:0]         pat_q [MAX_LEN-1:0];
    logic [2:0]         pat_d [MAX_LEN-1:0];
    logic [2:0]         nb_q, nb_d;
    logic               valid_q, valid_d;
    logic [2:0]         code_q, code_d;
`ifdef SITESWAP_MAXHEIGHT_EN
    logic [2:0]         maxt_q, maxt_d;
    logic [2:0]         max_digit;
`endif

    logic [2:0] cur_idx;
    logic [2:0] cur_digit;
    logic [3:0] land_sum;
    logic [2:0] landing;

    // CHK spends one trailing cycle at idx==len before publishing, so the
    // buffer read is masked back into range for that cycle.
    always_comb begin
        cur_idx   = (idx_q < len_q) ? idx_q : 3'd0;
        cur_digit = pbuf_q[cur_idx];
        land_sum  = {1'b0, idx_q} + {1'b0, cur_digit};
        landing   = 3'd0;
        if (len_q != 3'd0) begin
            landing = 3'(land_sum % {1'b0, len_q});
        end
    end

`ifdef SITESWAP_MAXHEIGHT_EN
    always_comb begin
        max_digit = 3'd0;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (3'(k) < len_q && pbuf_q[k] > max_digit) begin
                max_digit = pbuf_q[k];
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        pbuf_d  = pbuf_q;
        len_d   = len_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        q_d     = q_q;
        occ_d   = occ_q;
        pat_d   = pat_q;
        nb_d    = nb_q;
        valid_d = valid_q;
        code_d  = code_q;
`ifdef SITESWAP_MAXHEIGHT_EN
        maxt_d  = maxt_q;
`endif

        if (clear_in) begin
            state_d = S_ENTRY;
            len_d   = 3'd0;
            valid_d = 1'b0;
            code_d  = ERR_NONE;
            nb_d    = 3'd0;
            for (int k = 0; k < MAX_LEN; k++) pat_d[k] = 3'd0;
`ifdef SITESWAP_MAXHEIGHT_EN
            maxt_d  = 3'd0;
`endif
        end else begin
            case (state_q)
                // DONE lasts one cycle and behaves as ENTRY; the published
                // result registers simply hold afterwards.
                S_ENTRY, S_DONE: begin
                    state_d = S_ENTRY;
                    if (commit_in) begin
                        valid_d = 1'b0;
                        code_d  = ERR_NONE;
                        idx_d   = 3'd0;
                        acc_d   = 6'd0;
                        q_d     = 3'd0;
                        occ_d   = '0;
                        if (len_q == 3'd0) begin
                            state_d = S_ERR;
                            code_d  = ERR_EMPTY;
                        end else begin
                            state_d = S_SUM;
                        end
                    end else if (digit_valid_in && len_q != LEN_FULL) begin
                        pbuf_d[len_q] = digit_in;
                        len_d         = len_q + 3'd1;
                    end
                end

                S_SUM: begin
`ifdef SITESWAP_MAXHEIGHT_EN
                    if ({1'b0, cur_digit} > THROW_LIM) begin
                        state_d = S_ERR;
                        code_d  = ERR_HIGH;
                    end else
`endif
                    begin
                        acc_d = acc_q + 6'(cur_digit);
                        if (idx_q == len_q - 3'd1) begin
                            idx_d   = 3'd0;
                            state_d = S_DIV;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end

                // One subtraction per cycle; the exit cycle sees rem < len.
                S_DIV: begin
                    if (acc_q >= {3'd0, len_q}) begin
                        acc_d = acc_q - {3'd0, len_q};
                        q_d   = q_q + 3'd1;
                    end else if (acc_q != 6'd0) begin
                        state_d = S_ERR;
                        code_d  = ERR_FRAC;
                    end else if (q_q == 3'd0) begin
                        state_d = S_ERR;
                        code_d  = ERR_ZERO;
                    end else begin
                        idx_d   = 3'd0;
                        state_d = S_CHK;
                    end
                end

                S_CHK: begin
                    if (idx_q == len_q) begin
                        state_d = S_DONE;
                        valid_d = 1'b1;
                        code_d  = ERR_NONE;
                        nb_d    = q_q;
                        for (int k = 0; k < MAX_LEN; k++) begin
                            pat_d[k] = pbuf_q[3'(k) % len_q];
                        end
`ifdef SITESWAP_MAXHEIGHT_EN
                        maxt_d  = max_digit;
`endif
                    end else if (occ_q[landing]) begin
                        state_d = S_ERR;
                        code_d  = ERR_COLL;
                    end else begin
                        occ_d[landing] = 1'b1;
                        idx_d          = idx_q + 3'd1;
                    end
                end

                // Held until clear; buffer kept for inspection of len_out.
                S_ERR: ;

                default: state_d = S_ENTRY;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_ENTRY;
            len_q   <= 3'd0;
            idx_q   <= 3'd0;
            acc_q   <= 6'd0;
            q_q     <= 3'd0;
            occ_q   <= '0;
            nb_q    <= 3'd0;
            valid_q <= 1'b0;
            code_q  <= ERR_NONE;
            for (int k = 0; k < MAX_LEN; k++) begin
                pbuf_q[k] <= 3'd0;
                pat_q[k]  <= 3'd0;
            end
`ifdef SITESWAP_MAXHEIGHT_EN
            maxt_q  <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            occ_q   <= occ_d;
            nb_q    <= nb_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            pbuf_q  <= pbuf_d;
            pat_q   <= pat_d;
`ifdef SITESWAP_MAXHEIGHT_EN
            maxt_q  <= maxt_d;
`endif
        end
    end

    assign pattern_out       = pat_q;
    assign num_balls_out     = nb_q;
    assign len_out           = len_q;
    assign pattern_valid_out = valid_q;
    assign busy_out          = (state_q == S_SUM) || (state_q == S_DIV) || (state_q == S_CHK);
    assign error_out         = (state_q == S_ERR);
    assign error_code_out    = code_q;
`ifdef SITESWAP_MAXHEIGHT_EN
    assign max_throw_out     = maxt_q;
`endif

endmodule

// File: tb/tb_siteswap_loader.sv
module tb_siteswap_loader;

`ifdef SITESWAP_MAXHEIGHT_EN
    localparam int TB_MAX_THROW = 5;
`else
    localparam int TB_MAX_THROW = 7;
`endif
    localparam int TB_LEN = 7;
    localparam int WAIT_LIMIT = 300;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [2:0] digit_in = 3'd0;
    logic       digit_valid_in = 1'b0;
    logic       commit_in = 1'b0;
    logic       clear_in = 1'b0;
    logic [2:0] pattern_out [TB_LEN-1:0];
    logic [2:0] num_balls_out;
    logic [2:0] len_out;
    logic       pattern_valid_out;
    logic       busy_out;
    logic       error_out;
    logic [2:0] error_code_out;
`ifdef SITESWAP_MAXHEIGHT_EN
    logic [2:0] max_throw_out;
`endif

    siteswap_loader #(.MAX_LEN(TB_LEN), .MAX_THROW(TB_MAX_THROW)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .digit_in         (digit_in),
        .digit_valid_in   (digit_valid_in),
        .commit_in        (commit_in),
        .clear_in         (clear_in),
        .pattern_out      (pattern_out),
        .num_balls_out    (num_balls_out),
        .len_out          (len_out),
        .pattern_valid_out(pattern_valid_out),
        .busy_out         (busy_out),
        .error_out        (error_out),
        .error_code_out   (error_code_out)
`ifdef SITESWAP_MAXHEIGHT_EN
        ,
        .max_throw_out    (max_throw_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit valid;
        int code;
        int nb;
        int lat;
        int mx;
        int pat[TB_LEN];
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   md[$];        // model of the entry buffer
    exp_t sb[$];        // expected results awaiting DUT output

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    function automatic exp_t model();
        exp_t e;
        int   len, sum;
        bit   occ[TB_LEN];
        e.valid = 0; e.code = 0; e.nb = 0; e.lat = 0; e.mx = 0;
        for (int k = 0; k < TB_LEN; k++) e.pat[k] = 0;
        len = md.size();
        if (len == 0) begin
            e.code = 1;
            return e;
        end
        foreach (md[i]) if (md[i] > TB_MAX_THROW) begin
            e.code = 5;
            return e;
        end
        sum = 0;
        foreach (md[i]) sum += md[i];
        if (sum % len != 0) begin e.code = 2; return e; end
        if (sum / len == 0) begin e.code = 4; return e; end
        for (int k = 0; k < TB_LEN; k++) occ[k] = 0;
        for (int i = 0; i < len; i++) begin
            int land;
            land = (i + md[i]) % len;
            if (occ[land]) begin e.code = 3; return e; end
            occ[land] = 1;
        end
        e.valid = 1;
        e.nb    = sum / len;
        e.lat   = 2 * len + e.nb + 2;
        for (int k = 0; k < TB_LEN; k++) e.pat[k] = md[k % len];
        foreach (md[i]) if (md[i] > e.mx) e.mx = md[i];
        return e;
    endfunction

    task automatic pulse_digit(input int d);
        digit_in = 3'(d);
        digit_valid_in = 1'b1;
        tick();
        digit_valid_in = 1'b0;
    endtask

    task automatic enter_digit(input int d);
        pulse_digit(d);
        if (md.size() < TB_LEN) md.push_back(d);
    endtask

    task automatic do_clear();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        md.delete();
    endtask

    task automatic commit_and_check(input string tag, input bit with_digit);
        exp_t e;
        int   n;
        int   len_before;
        len_before = md.size();
        sb.push_back(model());
        commit_in = 1'b1;
        digit_valid_in = with_digit;
        digit_in = 3'd2;
        tick();
        commit_in = 1'b0;
        digit_valid_in = 1'b0;
        check({tag, ":valid_fell"}, pattern_valid_out, 0);
        check({tag, ":busy"}, busy_out, (len_before > 0) ? 1 : 0);
        n = 0;
        while (!(pattern_valid_out || error_out) && n < WAIT_LIMIT) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        if (n >= WAIT_LIMIT) begin
            checks++;
            failures++;
            $error("FAIL %s:timeout observed=%0d expected=%0d", tag, n, e.lat);
        end else begin
            check({tag, ":valid"}, pattern_valid_out, e.valid);
            check({tag, ":error"}, error_out, !e.valid);
            check({tag, ":code"}, error_code_out, e.code);
            check({tag, ":len"}, len_out, len_before);
            if (e.valid) begin
                check({tag, ":latency"}, n, e.lat);
                check({tag, ":balls"}, num_balls_out, e.nb);
                for (int k = 0; k < TB_LEN; k++)
                    check($sformatf("%s:pat%0d", tag, k), pattern_out[k], e.pat[k]);
`ifdef SITESWAP_MAXHEIGHT_EN
                check({tag, ":maxthrow"}, max_throw_out, e.mx);
`endif
            end
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst:valid", pattern_valid_out, 0);
        check("rst:error", error_out, 0);
        check("rst:code", error_code_out, 0);
        check("rst:len", len_out, 0);
        check("rst:busy", busy_out, 0);
        check("rst:balls", num_balls_out, 0);
        rst_in = 1'b0;
        tick();

        // 531
        enter_digit(5); enter_digit(3); enter_digit(1);
        check("531:len_pre", len_out, 3);
        commit_and_check("531", 0);

        // single 3
        do_clear();
        enter_digit(3);
        commit_and_check("3", 0);

        // collision, then inputs ignored in ERR
        do_clear();
        enter_digit(5); enter_digit(4); enter_digit(3);
        commit_and_check("543", 0);
        pulse_digit(2);
        commit_in = 1'b1; tick(); commit_in = 1'b0;
        check("err_hold:len", len_out, 3);
        check("err_hold:error", error_out, 1);
        check("err_hold:code", error_code_out, 3);

        // non-integer average, zero balls, empty
        do_clear();
        enter_digit(5); enter_digit(4);
        commit_and_check("54", 0);
        do_clear();
        enter_digit(0);
        commit_and_check("0", 0);
        do_clear();
        commit_and_check("empty", 0);

        // overflow of the entry buffer
        do_clear();
        for (int i = 0; i < 8; i++) enter_digit(4);
        check("full:len", len_out, 7);
        commit_and_check("4x7", 0);
        do_clear();
        check("clr:valid", pattern_valid_out, 0);
        check("clr:error", error_out, 0);
        check("clr:code", error_code_out, 0);
        check("clr:len", len_out, 0);
        check("clr:balls", num_balls_out, 0);
        check("clr:pat0", pattern_out[0], 0);
        check("clr:pat6", pattern_out[6], 0);

        // asynchronous reset mid-SUM
        enter_digit(4); enter_digit(4); enter_digit(1);
        commit_in = 1'b1; tick(); commit_in = 1'b0;
        tick();
        check("mid:busy_pre", busy_out, 1);
        #2 rst_in = 1'b1;
        #1;
        check("arst:busy", busy_out, 0);
        check("arst:len", len_out, 0);
        check("arst:valid", pattern_valid_out, 0);
        check("arst:error", error_out, 0);
        #2 rst_in = 1'b0;
        md.delete();
        tick();

        // re-entry, then commit colliding with a digit strobe
        enter_digit(4); enter_digit(4); enter_digit(1);
        commit_and_check("441", 0);
        commit_and_check("441_dig", 1);
        check("441_dig:len_after", len_out, 3);

`ifdef SITESWAP_MAXHEIGHT_EN
        do_clear();
        enter_digit(7); enter_digit(1);
        commit_and_check("71_high", 0);
        do_clear();
        check("clr:maxthrow", max_throw_out, 0);
        enter_digit(5); enter_digit(3); enter_digit(1);
        commit_and_check("531_max", 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
